// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the 4-MAC systolic datapath: steps weight/input memories and MAC enables
// through PRIME, four-phase STEPs, optional STALLs, DRAIN and a per-layer result strobe.
module systolic_seq_ctrl #(
  parameter int N_INPUTS  = 4,
  parameter int N_LAYERS  = 2,
  parameter int DRAIN_CYC = 3,
  parameter int SW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
  parameter int LW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hold,
  output logic          busy,
  output logic          done,
  output logic [2:0]    w_load,
  output logic          in_load_en,
  output logic          mac_en_lo,
  output logic          mac_en_hi,
  output logic          acc_clr,
  output logic          out_valid,
  output logic [LW-1:0] layer_idx,
  output logic [SW-1:0] step_idx,
  output logic [2:0]    dbg_state
);

  // Handshake: start is a level request sampled only in IDLE; hold is a level
  // request sampled only on the cycle before a step boundary. No ready is returned.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRIME     = 3'd1,
    STEP      = 3'd2,
    STALL     = 3'd3,
    DRAIN     = 3'd4,
    LAYER_END = 3'd5
  } state_t;

  // One counter serves PRIME (2 cycles) and DRAIN (DRAIN_CYC cycles).
  localparam int CW = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;

  state_t        state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] step_q, step_d;
  logic [LW-1:0] layer_q, layer_d;
  logic          in_step_d;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    layer_d = layer_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PRIME;
          cnt_d   = '0;
        end
      end
      PRIME: begin
        if (cnt_q == CW'(1)) begin
          state_d = hold ? STALL : STEP;
          phase_d = 2'd0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STALL: begin
        phase_d = 2'd0;
        if (!hold) state_d = STEP;
      end
      STEP: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          if (step_q == SW'(N_INPUTS - 1)) begin
            cnt_d   = '0;
            state_d = (DRAIN_CYC == 0) ? LAYER_END : DRAIN;
          end else begin
            step_d  = step_q + SW'(1);
            state_d = hold ? STALL : STEP;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(DRAIN_CYC - 1)) state_d = LAYER_END;
        else cnt_d = cnt_q + CW'(1);
      end
      LAYER_END: begin
        step_d  = '0;
        phase_d = 2'd0;
        if (layer_q == LW'(N_LAYERS - 1)) begin
          layer_d = '0;
          state_d = IDLE;
        end else begin
          layer_d = layer_q + LW'(1);
          state_d = hold ? STALL : STEP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_step_d = (state_d == STEP);

  // Strobes are decoded from the next state so they leave flops aligned with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= 2'd0;
      cnt_q      <= '0;
      step_q     <= '0;
      layer_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      w_load     <= 3'b000;
      in_load_en <= 1'b0;
      mac_en_lo  <= 1'b0;
      mac_en_hi  <= 1'b0;
      acc_clr    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      layer_q    <= layer_d;
      busy       <= (state_d != IDLE);
      done       <= (state_d == LAYER_END) && (layer_d == LW'(N_LAYERS - 1));
      w_load     <= (in_step_d && phase_d == 2'd0) ? 3'b001 :
                    (in_step_d && phase_d == 2'd2) ? 3'b010 : 3'b000;
      in_load_en <= in_step_d && (phase_d == 2'd1);
      mac_en_lo  <= in_step_d && (phase_d == 2'd1);
      mac_en_hi  <= in_step_d && (phase_d == 2'd3);
      acc_clr    <= in_step_d && (phase_d == 2'd0) && (step_d == '0);
      out_valid  <= (state_d == LAYER_END);
    end
  end

  assign layer_idx = layer_q;
  assign step_idx  = step_q;
  assign dbg_state = state_q;

endmodule

// File: doc/systolic_seq_ctrl.md
# systolic_seq_ctrl

Sequencer for the 4-MAC systolic datapath. It drives `weight_mem_if` (`load` codes `3'b001`/`3'b010`) and `input_mem_if` (`load_en`). It also produces the MAC enables, accumulator clear and per-layer result strobe, so that every weight line is paired with exactly one input sample. It sits between the top-level run control and the two memory interfaces and the MAC array.

## Interface
Parameters:
- `N_INPUTS`, default 4: steps per layer; each step consumes one weight line and one input sample. Legal range ≥1.
- `N_LAYERS`, default 2: layers per run. Legal range ≥1.
- `DRAIN_CYC`, default 3: MAC pipeline drain cycles after the last step of a layer. Legal range ≥0.
- `SW = max(1,$clog2(N_INPUTS))`, `LW = max(1,$clog2(N_LAYERS))`: derived widths.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: run request; sampled only in IDLE.
- `hold` input 1: stall request; sampled only at step boundaries.
- `busy` output 1: high from PRIME through the last LAYER_END inclusive.
- `done` output 1: one-cycle pulse, coincident with the final `out_valid`.
- `w_load` output 3: to `weight_mem_if.load`; values are `3'b000`, `3'b001` or `3'b010` only.
- `in_load_en` output 1: to `input_mem_if.load_en`.
- `mac_en_lo` output 1: enable for MACs 0,1.
- `mac_en_hi` output 1: enable for MACs 2,3.
- `acc_clr` output 1: accumulator clear for all MACs.
- `out_valid` output 1: one-cycle layer-result strobe.
- `layer_idx` output LW: current layer.
- `step_idx` output SW: current step within the layer.

## Operation
- States: IDLE, PRIME, STEP, STALL, DRAIN, LAYER_END.
  - STEP has a 2-bit phase P0..P3.
  - PRIME and DRAIN each use a cycle counter.
- IDLE → PRIME when `start`=1. PRIME lasts exactly 2 cycles; this covers the 2-cycle input read pipeline.
- At each step boundary the FSM decides between P0 and STALL. A step boundary is the cycle after PRIME, after P3 of a non-final step, or after LAYER_END of a non-final layer.
  - `hold`=1: go to STALL.
  - `hold`=0: go to P0.
  - STALL re-evaluates `hold` every cycle.
  - STALL outputs are all strobes low; indices hold.
- Strobe assignments within STEP:
  - P0: `w_load`=001. `acc_clr`=1 only when `step_idx`=0.
  - P1: `mac_en_lo`=1 and `in_load_en`=1.
  - P2: `w_load`=010; the weight line address advances at the end of P2.
  - P3: `mac_en_hi`=1.
- Step advance:
  - After P3 with `step_idx`<N_INPUTS-1: increment `step_idx` and go to the step boundary.
  - After P3 of the last step: go to DRAIN for DRAIN_CYC cycles (skip DRAIN if 0), then LAYER_END.
- LAYER_END lasts one cycle with `out_valid`=1.
  - Non-final layer: increment `layer_idx`, clear `step_idx`, go to the step boundary.
  - Final layer: assert `done`=1 in the same cycle, then return to IDLE.
- On return to IDLE, `layer_idx` and `step_idx` return to 0.
- `start` is ignored while `busy`=1.
- `hold` has no effect outside step boundaries; an in-flight step always completes all four phases.
- Weight lines and input samples are consumed strictly in order, one of each per step. A run consumes N_INPUTS·N_LAYERS of each, and both address counters wrap in their own blocks.
- Reset at any time forces IDLE on the next edge.
  - All outputs go to 0: `busy`, `done`, `w_load`=000, `in_load_en`, both MAC enables, `acc_clr`, `out_valid`, `layer_idx`, `step_idx`.
  - Both memory interfaces share `rst`, so their addresses realign to 0.
  - No partial layer result is flagged.

## Timing
- All outputs are registered and decoded from state; they are valid in the cycle the state is held.
- `start` high in cycle t puts PRIME in cycles t+1 and t+2, and P0 in cycle t+3 if `hold`=0.
- Weight alignment:
  - `w_load`=001 in P0, so w0/w1 are valid in P1 when `mac_en_lo` samples them.
  - `w_load`=010 in P2, so w2/w3 are valid in P3 when `mac_en_hi` samples them.
- Input alignment: `in_load_en` in P1 changes the input address at the end of P1, and the new `a_out` is visible from the next P0. Therefore P1 and P3 of a step both see the same sample.
- Busy duration with no stalls: 2 + N_LAYERS·(4·N_INPUTS + DRAIN_CYC + 1) cycles. Each STALL cycle adds one.
- `busy` falls in the cycle after `done`.

## Test plan
- Nominal run, N_INPUTS=2, N_LAYERS=2, DRAIN_CYC=3, start at cycle 0:
  - `busy` is high in cycles 1–26.
  - `w_load` follows 001,000,010,000 per step.
  - `acc_clr` is high in cycles 3 and 15; `out_valid` in cycles 14 and 26; `done` in cycle 26.
  - 4 `in_load_en` pulses and 4 `w_load`=010 pulses occur in total.
- Data pairing: weight line k = {4{16'h0k0k}} and input k = 16'h00k0. In every `mac_en_lo`/`mac_en_hi` cycle, `a_out` = 16'h00k0 and the active half equals 16'h0k0k, for k=0..3.
- Hold: `hold`=1 held for 3 cycles across the step-0/step-1 boundary.
  - Exactly 3 STALL cycles with all strobes low.
  - `busy` lasts 29 cycles and pairing is still correct.
  - `hold` asserted mid-step (during P1) has no effect.
- `start` pulsed again during a run and during `done`: ignored, with no extra PRIME.
- Reset mid-run in P2 of step 1 of layer 0:
  - All outputs are 0 next cycle.
  - A new `start` reproduces the nominal run from weight line 0 and input 0.
- Corner case N_INPUTS=1, N_LAYERS=1, DRAIN_CYC=0: `busy` is 7 cycles, `acc_clr` is in cycle 3, and `out_valid` and `done` are together in cycle 7.
